// File: rtl/stride_perm.sv
`default_nettype none
// ============================================================================
// stride_perm : L(N_POINTS,STRIDE) stride permutation over ping-pong frame banks.
// Optional macro STRIDE_PERM_INVERSE_EN adds per-frame inverse L(N_POINTS,M).
// Rev 1.0
// ============================================================================
module stride_perm #(
  parameter int NB_DATA  = 16,
  parameter int N_POINTS = 32,
  parameter int N_PORTS  = 4,
  parameter int STRIDE   = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [N_POINTS*NB_DATA-1:0]   i_data,
  input  logic                          i_valid,
  input  logic                          i_enable,
`ifdef STRIDE_PERM_INVERSE_EN
  input  logic                          i_inverse,
`endif
  output logic                          o_ready,
  output logic [N_PORTS*NB_DATA-1:0]    o_data,
  output logic                          o_valid,
  output logic                          o_last,
  input  logic                          i_out_ready
);

  localparam int M     = N_POINTS / STRIDE;
  localparam int BEATS = N_POINTS / N_PORTS;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int FW    = N_POINTS * NB_DATA;
  localparam int PW    = N_PORTS * NB_DATA;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  typedef enum logic [1:0] {B_EMPTY = 2'd0, B_FULL = 2'd1, B_DRAIN = 2'd2} bank_st_e;
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_DRAIN = 1'b1} rd_st_e;

  logic [FW-1:0]  bank_q [2];
  bank_st_e       bank_st_q [2];
  bank_st_e       bank_st_d [2];
  rd_st_e         st_q, st_d;
  logic           wr_ptr_q, wr_ptr_d;
  logic           rd_ptr_q, rd_ptr_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [PW-1:0]  data_q, data_d;
  logic           valid_q, valid_d;
  logic           last_q, last_d;
  logic           ready_q, ready_d;
  logic           accept;
  logic           start;
  logic           start_bank;
  logic           inv_rd;
  logic           inv_st;

  // Samples for beat k of one frame; inv selects L(N_POINTS, M) instead.
  function automatic logic [PW-1:0] f_beat(input logic [FW-1:0] frame,
                                           input logic [BW-1:0] k,
                                           input logic          inv);
    logic [PW-1:0] beat;
    int j;
    int src;
    beat = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      j   = int'(k) * N_PORTS + p;
      src = inv ? ((j % STRIDE) * M + j / STRIDE) : ((j % M) * STRIDE + j / M);
      beat[p*NB_DATA +: NB_DATA] = frame[src*NB_DATA +: NB_DATA];
    end
    return beat;
  endfunction

`ifdef STRIDE_PERM_INVERSE_EN
  logic inv_q [2];
  assign inv_rd = inv_q[rd_ptr_q];
  assign inv_st = inv_q[start_bank];

  always_ff @(posedge i_clk) begin
    if (accept) inv_q[wr_ptr_q] <= i_inverse;
  end
`else
  assign inv_rd = 1'b0;
  assign inv_st = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (accept) bank_q[wr_ptr_q] <= i_data;
  end

  always_comb begin
    bank_st_d  = bank_st_q;
    st_d       = st_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    beat_d     = beat_q;
    data_d     = data_q;
    valid_d    = valid_q;
    last_d     = last_q;
    start      = 1'b0;
    start_bank = rd_ptr_q;
    accept     = i_enable & i_valid & ready_q;

    if (i_enable) begin
      if (accept) begin
        bank_st_d[wr_ptr_q] = B_FULL;
        wr_ptr_d            = ~wr_ptr_q;
      end
      unique case (st_q)
        S_IDLE: begin
          if (bank_st_q[rd_ptr_q] == B_FULL) start = 1'b1;
        end
        S_DRAIN: begin
          if (valid_q && i_out_ready) begin
            if (beat_q != LAST) begin
              beat_d = beat_q + BW'(1);
              data_d = f_beat(bank_q[rd_ptr_q], beat_d, inv_rd);
              last_d = (beat_d == LAST);
            end else begin
              // Final beat accepted: release this bank, chain straight into the other if loaded.
              bank_st_d[rd_ptr_q] = B_EMPTY;
              rd_ptr_d            = ~rd_ptr_q;
              if (bank_st_q[~rd_ptr_q] == B_FULL) begin
                start      = 1'b1;
                start_bank = ~rd_ptr_q;
              end else begin
                st_d    = S_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                beat_d  = '0;
              end
            end
          end
        end
        default: st_d = S_IDLE;
      endcase
      if (start) begin
        bank_st_d[start_bank] = B_DRAIN;
        st_d    = S_DRAIN;
        beat_d  = '0;
        data_d  = f_beat(bank_q[start_bank], '0, inv_st);
        valid_d = 1'b1;
        last_d  = (LAST == '0);
      end
    end
    ready_d = (bank_st_d[wr_ptr_d] == B_EMPTY);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bank_st_q[0] <= B_EMPTY;
      bank_st_q[1] <= B_EMPTY;
      st_q         <= S_IDLE;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      beat_q       <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      bank_st_q <= bank_st_d;
      st_q      <= st_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      beat_q    <= beat_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      ready_q   <= ready_d;
    end
  end

  assign o_ready = ready_q;
  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_last  = last_q;

endmodule
`default_nettype wire

// File: tb/tb_stride_perm.sv
`default_nettype none
// tb_stride_perm : directed stimulus with a frame-level permutation model and literal pins.
module tb_stride_perm;

  localparam int NB    = 16;
  localparam int NP    = 32;
  localparam int NPORT = 4;
  localparam int S     = 8;
  localparam int M     = NP / S;
  localparam int BEATS = NP / NPORT;
  localparam int FW    = NP * NB;
  localparam int PW    = NPORT * NB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [FW-1:0] data = '0;
  logic          valid = 1'b0;
  logic          enable = 1'b1;
  logic          out_ready = 1'b1;
  logic          inverse = 1'b0;

  logic          o_ready, o_valid, o_last;
  logic [PW-1:0] o_data;
  logic          s4_ready, s4_valid, s4_last;
  logic [PW-1:0] s4_data;

  int n_chk  = 0;
  int n_fail = 0;

  stride_perm #(.NB_DATA(NB), .N_POINTS(NP), .N_PORTS(NPORT), .STRIDE(S)) u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_data      (data),
    .i_valid     (valid),
    .i_enable    (enable),
`ifdef STRIDE_PERM_INVERSE_EN
    .i_inverse   (inverse),
`endif
    .o_ready     (o_ready),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_last      (o_last),
    .i_out_ready (out_ready)
  );

  stride_perm #(.NB_DATA(NB), .N_POINTS(NP), .N_PORTS(NPORT), .STRIDE(4)) u_s4 (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_data      (data),
    .i_valid     (valid),
    .i_enable    (enable),
`ifdef STRIDE_PERM_INVERSE_EN
    .i_inverse   (1'b0),
`endif
    .o_ready     (s4_ready),
    .o_data      (s4_data),
    .o_valid     (s4_valid),
    .o_last      (s4_last),
    .i_out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] mk(input int base);
    logic [FW-1:0] f;
    for (int i = 0; i < NP; i++) f[i*NB +: NB] = 16'(base + i);
    return f;
  endfunction

  // Reference: build the whole permuted frame y, then slice it into consecutive beats.
  logic [PW-1:0] exp_q[$];
  bit            expl_q[$];

  task automatic push_frame(input logic [FW-1:0] fr, input bit inv);
    logic [FW-1:0] y;
    int src;
    for (int j = 0; j < NP; j++) begin
      if (inv) src = (j % S) * M + j / S;
      else     src = (j % M) * S + j / M;
      y[j*NB +: NB] = fr[src*NB +: NB];
    end
    for (int k = 0; k < BEATS; k++) begin
      exp_q.push_back(y[k*PW +: PW]);
      expl_q.push_back(k == BEATS - 1);
    end
  endtask

  bit            pend_out = 1'b0;
  bit            pend_in  = 1'b0;
  logic [FW-1:0] pend_fr;
  bit            pend_inv;

  always @(negedge clk) begin
    if (pend_out && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      void'(expl_q.pop_front());
    end
    if (pend_in) push_frame(pend_fr, pend_inv);
    pend_out = 1'b0;
    pend_in  = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      expl_q.delete();
    end else begin
      if (o_valid) begin
        if (exp_q.size() == 0) chk("unexpected_beat", PW'(1), PW'(0));
        else begin
          chk("beat_data", o_data, exp_q[0]);
          chk("beat_last", PW'(o_last), PW'(expl_q[0]));
        end
      end
      pend_out = o_valid & out_ready & enable;
      pend_in  = valid & enable & o_ready;
      pend_fr  = data;
      pend_inv = inverse;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!o_valid) break;
      tick();
    end
    chk("drain_done", PW'(o_valid), PW'(0));
  endtask

  task automatic send(input logic [FW-1:0] fr);
    data  = fr;
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("reset_valid", PW'(o_valid), PW'(0));
    chk("reset_last",  PW'(o_last),  PW'(0));
    chk("reset_ready", PW'(o_ready), PW'(1));
    chk("reset_data",  o_data,       '0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single frame x[i]=i, always ready
    send(mk(0));
    chk("latency_not_early", PW'(o_valid), PW'(0));
    chk("ready_after_one", PW'(o_ready), PW'(1));
    tick();
    chk("first_valid", PW'(o_valid), PW'(1));
    chk("beat0_lit", o_data, 64'h0018_0010_0008_0000);
    chk("s4_beat0_lit", s4_data, 64'h000C_0008_0004_0000);
    chk("beat0_not_last", PW'(o_last), PW'(0));
    for (int k = 1; k < BEATS; k++) begin
      tick();
      if (k == 1) chk("s4_beat1_lit", s4_data, 64'h001C_0018_0014_0010);
    end
    chk("beat7_lit", o_data, 64'h001F_0017_000F_0007);
    chk("beat7_last", PW'(o_last), PW'(1));
    tick();
    chk("idle_after_frame", PW'(o_valid), PW'(0));

    // Back-to-back A, B and a third frame C refused until A's final beat
    send(mk(0));
    data  = mk(100);
    valid = 1'b1;
    tick();
    data = mk(200);
    for (int t = 0; t < 3 * BEATS; t++) begin
      chk("contiguous_valid", PW'(o_valid), PW'(1));
      if (t < BEATS) chk("c_refused", PW'(o_ready), PW'(0));
      if (t == BEATS) begin
        chk("ready_after_a", PW'(o_ready), PW'(1));
        chk("b_beat0_lit", o_data, 64'h007C_0074_006C_0064);
      end
      if (t == BEATS + 1) valid = 1'b0;
      tick();
    end
    chk("idle_after_abc", PW'(o_valid), PW'(0));

    // Backpressure for 3 cycles on beat 2
    send(mk(0));
    tick();
    tick();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_data", o_data, 64'h001A_0012_000A_0002);
      chk("bp_hold_valid", PW'(o_valid), PW'(1));
    end
    out_ready = 1'b1;
    wait_idle();

    // Enable low for 4 cycles mid-drain with a frame offered
    send(mk(0));
    for (int i = 0; i < 4; i++) tick();
    enable = 1'b0;
    data   = mk(300);
    valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("freeze_data", o_data, 64'h001B_0013_000B_0003);
      chk("freeze_valid", PW'(o_valid), PW'(1));
    end
    enable = 1'b1;
    valid  = 1'b0;
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_capture", PW'(o_valid), PW'(0));
    end

    // Asynchronous reset during beat 4
    send(mk(0));
    for (int i = 0; i < 5; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", PW'(o_valid), PW'(0));
    chk("arst_ready", PW'(o_ready), PW'(1));
    chk("arst_last",  PW'(o_last),  PW'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(mk(50));
    tick();
    chk("post_reset_beat0_lit", o_data, 64'h004A_0042_003A_0032);
    wait_idle();

`ifdef STRIDE_PERM_INVERSE_EN
    inverse = 1'b1;
    send(mk(0));
    inverse = 1'b0;
    tick();
    chk("inverse_beat0_lit", o_data, 64'h000C_0008_0004_0000);
    wait_idle();
`endif

    tick();
    tick();
    chk("model_queue_empty", PW'(exp_q.size()), PW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
